// File: rtl/instruction_issuer_if.sv
// Bundle of program-load, run-control and core-handshake signals for the instruction issuer.
// The slave modport is the issuer; the master modport is whatever drives it (loader + core).
interface instruction_issuer_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          loadEnable;
  logic [AW-1:0] loadAddr;
  logic [31:0]   loadData;
  logic [AW:0]   programLength;
  logic          start;
  logic          abort;
  logic          completeInstruction;

  logic [31:0]   instruction;
  logic          validInstruction;
  logic          busy;
  logic          done;
  logic          timeoutError;
  logic [AW-1:0] currentPC;
  logic [31:0]   issuedCount;
  logic [31:0]   completedCount;

  modport master (
    output loadEnable, loadAddr, loadData, programLength, start, abort, completeInstruction,
    input  instruction, validInstruction, busy, done, timeoutError, currentPC,
           issuedCount, completedCount
  );

  modport slave (
    input  loadEnable, loadAddr, loadData, programLength, start, abort, completeInstruction,
    output instruction, validInstruction, busy, done, timeoutError, currentPC,
           issuedCount, completedCount
  );
endinterface

// File: rtl/instruction_issuer.sv
// Issues a preloaded program one instruction at a time to a core, waiting for each
// completion (bounded by TIMEOUT cycles) before presenting the next word.
module instruction_issuer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  instruction_issuer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW:0]   DEPTH_LEN  = DEPTH[AW:0];
  localparam logic [AW:0]   ONE_LEN    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] FIRST_PC   = '0;
  // Last WAIT cycle before the error: the error state then starts TIMEOUT cycles after the strobe.
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERROR} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] pc;
  logic [AW-1:0] lastPc;
  logic [WW-1:0] waitCnt;
  logic [31:0]   instructionQ;
  logic [31:0]   issuedQ;
  logic [31:0]   completedQ;
  logic          validQ;
  logic          busyQ;
  logic          doneQ;
  logic          errorQ;

  logic [AW:0]   clampedLen;
  logic [AW:0]   lastIdx;
  logic [AW-1:0] nextPc;

  assign clampedLen = (bus.programLength > DEPTH_LEN) ? DEPTH_LEN : bus.programLength;
  assign lastIdx    = clampedLen - ONE_LEN;
  assign nextPc     = pc + 1'b1;

  // NOTE: the program buffer deliberately has no reset, so a reset keeps the loaded
  // program and avoids a reset fan-out to every storage bit.
  always_ff @(posedge clk) begin
    if (bus.loadEnable && !busyQ) begin
      mem[bus.loadAddr] <= bus.loadData;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      instructionQ <= '0;
      validQ       <= 1'b0;
      busyQ        <= 1'b0;
      doneQ        <= 1'b0;
      errorQ       <= 1'b0;
      pc           <= '0;
      lastPc       <= '0;
      waitCnt      <= '0;
      issuedQ      <= '0;
      completedQ   <= '0;
    end else if (bus.abort) begin
      state  <= IDLE;
      validQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      errorQ <= 1'b0;
    end else begin
      validQ <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            completedQ <= '0;
            pc         <= '0;
            errorQ     <= 1'b0;
            if (clampedLen == '0) begin
              state   <= DONE;
              busyQ   <= 1'b0;
              doneQ   <= 1'b1;
              issuedQ <= '0;
            end else begin
              // Counts restart at zero; the first strobe is already counted while it is shown.
              state        <= ISSUE;
              busyQ        <= 1'b1;
              doneQ        <= 1'b0;
              validQ       <= 1'b1;
              instructionQ <= mem[FIRST_PC];
              issuedQ      <= 32'd1;
              lastPc       <= lastIdx[AW-1:0];
            end
          end
        end

        ISSUE: begin
          state   <= WAIT;
          waitCnt <= '0;
        end

        WAIT: begin
          if (bus.completeInstruction) begin
            completedQ <= completedQ + 32'd1;
            if (pc == lastPc) begin
              state <= DONE;
              busyQ <= 1'b0;
              doneQ <= 1'b1;
            end else begin
              state        <= ISSUE;
              pc           <= nextPc;
              validQ       <= 1'b1;
              instructionQ <= mem[nextPc];
              issuedQ      <= issuedQ + 32'd1;
            end
          end else if (waitCnt == WAIT_LIMIT) begin
            state  <= ERROR;
            busyQ  <= 1'b0;
            errorQ <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busyQ <= 1'b0;
          doneQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instruction      = instructionQ;
  assign bus.validInstruction = validQ;
  assign bus.busy             = busyQ;
  assign bus.done             = doneQ;
  assign bus.timeoutError     = errorQ;
  assign bus.currentPC        = pc;
  assign bus.issuedCount      = issuedQ;
  assign bus.completedCount   = completedQ;
endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboard bench for instruction_issuer: runs push expected strobe words, a negedge
// monitor pops and compares them; directed checks cover counts, timing and interference.
module tb_instruction_issuer;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_issuer_if #(.DEPTH(DEPTH)) bus ();

  instruction_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          total    = 0;
  int          bad      = 0;
  int          strobes  = 0;
  bit          inFlight = 1'b0;
  logic [31:0] expq[$];
  logic [31:0] model[DEPTH];
  int          delays[7] = '{1, 2, 5, 1, 3, 1, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next expected word, one in flight at a time.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.validInstruction) begin
        strobes++;
        check("single_in_flight", 32'(inFlight), 32'd0);
        inFlight = 1'b1;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got %h required no strobe", bus.instruction);
        end else begin
          check("strobe_word", bus.instruction, expq.pop_front());
        end
      end else if (!bus.busy || bus.completeInstruction) begin
        inFlight = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    bus.loadEnable = 1'b1;
    bus.loadAddr   = 4'(addr);
    bus.loadData   = data;
    tick();
    bus.loadEnable = 1'b0;
    model[addr]    = data;
  endtask

  task automatic startRun(input int len);
    int l;
    l = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < l; i++) expq.push_back(model[i]);
    bus.programLength = 5'(len);
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic waitStrobe(input int budget, input string name);
    int n;
    n = 0;
    while (!bus.validInstruction && n < budget) begin
      tick();
      n++;
    end
    if (!bus.validInstruction) begin
      total++;
      bad++;
      $display("FAIL %s: got no strobe required strobe within %0d cycles", name, budget);
    end
  endtask

  // The first strobe of the batch must already have been presented when this is called.
  task automatic serve(input int n, input int fixedDelay, input bit vary);
    for (int i = 0; i < n; i++) begin
      if (i > 0) waitStrobe(4, "next_strobe");
      repeat (vary ? delays[i % 7] : fixedDelay) tick();
      bus.completeInstruction = 1'b1;
      tick();
      bus.completeInstruction = 1'b0;
    end
  endtask

  task automatic checkCleared(input string tag);
    check({tag, "_instruction"}, bus.instruction, 32'h0);
    check({tag, "_valid"}, 32'(bus.validInstruction), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_error"}, 32'(bus.timeoutError), 32'd0);
    check({tag, "_pc"}, 32'(bus.currentPC), 32'd0);
    check({tag, "_issued"}, bus.issuedCount, 32'd0);
    check({tag, "_completed"}, bus.completedCount, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    bus.loadEnable          = 1'b0;
    bus.loadAddr            = '0;
    bus.loadData            = '0;
    bus.programLength       = '0;
    bus.start               = 1'b0;
    bus.abort               = 1'b0;
    bus.completeInstruction = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkCleared("reset");

    // Single instruction, completion three cycles after the strobe.
    load(0, 32'h000000B3);
    startRun(1);
    check("latency_valid", 32'(bus.validInstruction), 32'd1);
    check("latency_busy", 32'(bus.busy), 32'd1);
    serve(1, 3, 1'b0);
    check("single_done", 32'(bus.done), 32'd1);
    check("single_issued", bus.issuedCount, 32'd1);
    check("single_completed", bus.completedCount, 32'd1);
    check("single_busy", 32'(bus.busy), 32'd0);
    check("single_held_word", bus.instruction, 32'h000000B3);

    // Seven-instruction program with varying completion delay.
    load(0, 32'h000000B3);
    load(1, 32'h40000133);
    load(2, 32'h000071B3);
    load(3, 32'h00006233);
    load(4, 32'h000042B3);
    load(5, 32'h00002333);
    load(6, 32'h000033B3);
    startRun(7);
    serve(7, 0, 1'b1);
    check("full_done", 32'(bus.done), 32'd1);
    check("full_issued", bus.issuedCount, 32'd7);
    check("full_completed", bus.completedCount, 32'd7);
    check("full_pc", 32'(bus.currentPC), 32'd6);

    // Timeout: no completion ever, error exactly TIMEOUT cycles after the strobe.
    startRun(2);
    repeat (TIMEOUT - 1) tick();
    check("timeout_not_early", 32'(bus.timeoutError), 32'd0);
    check("timeout_busy_before", 32'(bus.busy), 32'd1);
    tick();
    check("timeout_error", 32'(bus.timeoutError), 32'd1);
    check("timeout_busy", 32'(bus.busy), 32'd0);
    check("timeout_issued", bus.issuedCount, 32'd1);
    check("timeout_completed", bus.completedCount, 32'd0);
    bus.completeInstruction = 1'b1;
    tick();
    tick();
    bus.completeInstruction = 1'b0;
    check("error_ignores_complete", bus.completedCount, 32'd0);
    check("error_sticky", 32'(bus.timeoutError), 32'd1);
    check("timeout_unissued_left", 32'(expq.size()), 32'd1);
    expq.delete();

    // Restart from ERROR, completion lands on the last allowed WAIT cycle.
    startRun(1);
    check("restart_clears_error", 32'(bus.timeoutError), 32'd0);
    repeat (TIMEOUT - 1) tick();
    bus.completeInstruction = 1'b1;
    tick();
    bus.completeInstruction = 1'b0;
    check("edge_complete_no_error", 32'(bus.timeoutError), 32'd0);
    check("edge_complete_done", 32'(bus.done), 32'd1);
    check("edge_complete_count", bus.completedCount, 32'd1);

    // Zero-length program.
    s0 = strobes;
    startRun(0);
    check("len0_done", 32'(bus.done), 32'd1);
    check("len0_busy", 32'(bus.busy), 32'd0);
    check("len0_issued", bus.issuedCount, 32'd0);
    check("len0_completed", bus.completedCount, 32'd0);
    repeat (3) tick();
    check("len0_no_strobe", 32'(strobes - s0), 32'd0);

    // Oversized length clamps to DEPTH; completion held high gives one issue per 2 cycles.
    for (int i = 7; i < DEPTH; i++) load(i, 32'hA000_0000 + 32'(i));
    s0 = strobes;
    startRun(20);
    bus.completeInstruction = 1'b1;
    repeat (31) tick();
    check("len20_not_done_early", 32'(bus.done), 32'd0);
    tick();
    check("len20_done_on_time", 32'(bus.done), 32'd1);
    bus.completeInstruction = 1'b0;
    check("len20_strobes", 32'(strobes - s0), 32'd16);
    check("len20_issued", bus.issuedCount, 32'd16);
    check("len20_completed", bus.completedCount, 32'd16);
    check("len20_pc", 32'(bus.currentPC), 32'd15);

    // start and loadEnable while busy are dropped.
    startRun(3);
    bus.loadEnable    = 1'b1;
    bus.loadAddr      = 4'd1;
    bus.loadData      = 32'hDEADBEEF;
    bus.programLength = 5'd5;
    bus.start         = 1'b1;
    tick();
    bus.loadEnable = 1'b0;
    bus.start      = 1'b0;
    serve(3, 2, 1'b0);
    check("busy_start_ignored_issued", bus.issuedCount, 32'd3);
    check("busy_start_ignored_done", 32'(bus.done), 32'd1);
    startRun(2);
    serve(2, 1, 1'b0);
    check("rerun_issued", bus.issuedCount, 32'd2);

    // Abort during WAIT overrides a simultaneous completion and start.
    startRun(7);
    serve(2, 1, 1'b0);
    waitStrobe(4, "third_strobe");
    tick();
    bus.abort               = 1'b1;
    bus.completeInstruction = 1'b1;
    bus.start               = 1'b1;
    tick();
    bus.abort               = 1'b0;
    bus.completeInstruction = 1'b0;
    bus.start               = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_valid", 32'(bus.validInstruction), 32'd0);
    check("abort_issued_held", bus.issuedCount, 32'd3);
    check("abort_completed_held", bus.completedCount, 32'd2);
    check("abort_unissued_left", 32'(expq.size()), 32'd4);
    expq.delete();
    s0 = strobes;
    repeat (5) tick();
    check("abort_no_strobe", 32'(strobes - s0), 32'd0);

    // Reset during WAIT clears outputs but keeps the buffer.
    startRun(7);
    serve(1, 1, 1'b0);
    waitStrobe(4, "second_strobe");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkCleared("midrun_reset");
    check("reset_unissued_left", 32'(expq.size()), 32'd5);
    expq.delete();
    startRun(7);
    serve(7, 0, 1'b1);
    check("post_reset_done", 32'(bus.done), 32'd1);
    check("post_reset_issued", bus.issuedCount, 32'd7);
    check("post_reset_completed", bus.completedCount, 32'd7);

    tick();
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_issuer.md
INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

Interface
REQ-001 Parameter DEPTH, 16, number of program buffer entries (power of two).
REQ-002 Parameter TIMEOUT, 64, maximum WAIT cycles allowed per instruction before an error.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 loadEnable  in  1  write loadData into the buffer at loadAddr.
REQ-006 loadAddr  in  log2(DEPTH)  buffer write index.
REQ-007 loadData  in  32  RISC-V instruction word.
REQ-008 programLength  in  log2(DEPTH)+1  number of instructions to issue; sampled at start.
REQ-009 start  in  1  one-cycle run request.
REQ-010 abort  in  1  cancel the run.
REQ-011 instruction  out  32  word presented to the core.
REQ-012 validInstruction  out  1  one-cycle issue strobe to the core.
REQ-013 completeInstruction  in  1  core finished the current instruction.
REQ-014 busy  out  1  high in ISSUE or WAIT.
REQ-015 done  out  1  high in DONE.
REQ-016 timeoutError  out  1  high in ERROR.
REQ-017 currentPC  out  log2(DEPTH)  buffer index of the instruction in flight or next to issue.
REQ-018 issuedCount  out  32  strobes issued in the current run.
REQ-019 completedCount  out  32  completions accepted in the current run.

Function
REQ-020 States SHALL be IDLE, ISSUE, WAIT, DONE and ERROR; all outputs SHALL be registered.
REQ-021 Buffer write: when loadEnable=1 and busy=0, mem[loadAddr] SHALL take loadData; writes while busy=1 SHALL be dropped.
REQ-022 IDLE/DONE/ERROR plus start=1, with the latched length L:
- L = min(programLength, DEPTH).
- If L=0: go to DONE with both counts 0.
- Otherwise: clear both counts, set pc=0 and go to ISSUE.
REQ-023 Start latency: start=1 at edge N SHALL give validInstruction=1 during cycle N+1.
REQ-024 ISSUE lasts exactly one cycle:
- validInstruction=1.
- instruction=mem[pc].
- issuedCount increments.
- Next state is WAIT with the wait counter cleared.
REQ-025 completeInstruction SHALL be ignored in ISSUE, IDLE, DONE and ERROR.
REQ-026 WAIT with completeInstruction=1:
- completedCount increments.
- If pc=L-1, go to DONE with pc held.
- Otherwise pc increments and the next state is ISSUE.
REQ-027 WAIT with completeInstruction=0: the wait counter increments. When it reaches TIMEOUT-1, the next state is ERROR.
REQ-028 If completeInstruction=1 on the same cycle the timeout is reached, the completion SHALL win.
REQ-029 validInstruction SHALL be 0 outside ISSUE.
REQ-030 instruction SHALL hold the last issued word until the next ISSUE.
REQ-031 Strobe count: every run SHALL produce exactly L strobes, with at most one instruction in flight.
REQ-032 DONE and ERROR are sticky until start, abort or reset. start in ERROR clears timeoutError and re-runs per REQ-022.
REQ-033 abort=1 in any state SHALL give IDLE on the next cycle:
- validInstruction=0.
- Counts are held.
- abort overrides start and completeInstruction.
REQ-034 issuedCount and completedCount SHALL wrap modulo 2^32.
REQ-035 busy SHALL equal (state==ISSUE || state==WAIT).

Reset
REQ-036 reset=1 SHALL force the following on the next edge, overriding every other input:
- State IDLE.
- instruction=0, validInstruction=0.
- busy=0, done=0, timeoutError=0.
- currentPC=0, issuedCount=0, completedCount=0.
REQ-037 Reset mid-run SHALL abandon the in-flight instruction with no further strobe.
REQ-038 Buffer contents SHALL NOT be cleared by reset.

Verification
REQ-039 Single instruction:
- Stimulus: load mem[0]=0x000000B3, programLength=1, start; completeInstruction 3 cycles after the strobe.
- Required: one strobe carrying 0x000000B3, then done=1 with issuedCount=1 and completedCount=1.
REQ-040 Full program:
- Stimulus: load the seven ADD/SUB/AND/OR/XOR/SLT/SLTU words 0x000000B3, 0x40000133, 0x000071B3, 0x00006233, 0x000042B3, 0x00002333, 0x000033B3; programLength=7; variable completion delay.
- Required: strobes in buffer order, never two before a completion, done with both counts 7 and currentPC=6.
REQ-041 Timeout:
- Stimulus: programLength=2, completeInstruction never asserted.
- Required: timeoutError=1 exactly TIMEOUT cycles after the first strobe, issuedCount=1, completedCount=0, no second strobe.
REQ-042 Boundaries:
- programLength=0 -> DONE with both counts 0.
- programLength=20 -> exactly 16 strobes.
- completeInstruction held high continuously -> one issue per 2 cycles.
- Completion on the timeout cycle -> no error.
REQ-043 Interference:
- abort during WAIT -> IDLE next cycle, counts held.
- start or loadEnable while busy -> ignored, buffer unchanged.
- reset during WAIT -> all outputs 0, buffer intact; a rerun issues the same words.
